// File: rtl/fc_x_rd_if.sv
// Control, RTM read-port and output-stream signals of fc_x_rd.
// The block itself uses the slave side; whoever drives it uses the master side.
interface fc_x_rd_if #(
    parameter int S         = 4,
    parameter int R         = 16,
    parameter int AW        = 12,
    parameter int OUT_BYTES = 16
);
    logic                   start_pulse;
    logic [AW-1:0]          x_addr;
    logic [AW:0]            x_len;
    logic                   busy;
    logic                   done_pulse;
    logic                   rtm_rd_vld;
    logic [S-1:0]           rtm_rd_en;
    logic [S*AW-1:0]        rtm_rd_addr;
    logic [S*R*8-1:0]       rtm_dout;
    logic [OUT_BYTES*8-1:0] out_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   out_last;

    modport master (
        output start_pulse, x_addr, x_len, rtm_dout, out_rdy,
        input  busy, done_pulse, rtm_rd_vld, rtm_rd_en, rtm_rd_addr,
               out_data, out_vld, out_last
    );

    modport slave (
        input  start_pulse, x_addr, x_len, rtm_dout, out_rdy,
        output busy, done_pulse, rtm_rd_vld, rtm_rd_en, rtm_rd_addr,
               out_data, out_vld, out_last
    );
endinterface

// File: rtl/fc_x_rd.sv
// Reads FC input rows from RTM and streams each row as N OUT_BYTES-wide beats.
// Row reads are credit-gated against a small row FIFO so backpressure never drops data.
module fc_x_rd #(
    parameter int S         = 4,
    parameter int R         = 16,
    parameter int RTM_DEPTH = 4096,
    parameter int OUT_BYTES = 16,
    parameter int RD_LAT    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    fc_x_rd_if.slave bus
);
    localparam int AW     = $clog2(RTM_DEPTH);
    localparam int LW     = AW + 1;
    localparam int ROW_W  = S * R * 8;
    localparam int BEAT_W = OUT_BYTES * 8;
    localparam int N      = (S * R) / OUT_BYTES;
    localparam int KW     = (N > 1) ? $clog2(N) : 1;
    localparam int FD     = RD_LAT + 2;
    localparam int PW     = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW     = $clog2(FD + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]            addr, issue_addr, rd_addr;
    logic [LW-1:0]            rows_left, rows_base, rows_out;
    logic [CW-1:0]            credits, count;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [KW-1:0]            k;
    logic [RD_LAT:0]          vld_pipe;
    logic [ROW_W-1:0]         mem [FD];
    logic [N-1:0][BEAT_W-1:0] head;
    logic start_ok, issue, push, fifo_vld, hs, beat_end, pop, last_beat;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(RTM_DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign start_ok  = (state == IDLE) && bus.start_pulse;
    assign rows_base = start_ok ? bus.x_len : rows_left;
    assign push      = vld_pipe[RD_LAT];
    assign fifo_vld  = (count != '0);
    assign hs        = fifo_vld && bus.out_rdy;
    assign beat_end  = (k == KW'(N - 1));
    assign pop       = hs && beat_end;
    assign last_beat = fifo_vld && beat_end && (rows_out == LW'(1));

    // The first read goes out straight from IDLE so it lands in the cycle after start.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr;
        if (start_ok && (bus.x_len != '0)) begin
            issue      = 1'b1;
            issue_addr = bus.x_addr;
        end else if ((state == RUN) && (rows_left != '0) && (credits != '0)) begin
            issue = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_pulse) state_nxt = (bus.x_len != '0) ? RUN : FIN;
            RUN:     if (hs && last_beat) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state == RUN);
        bus.done_pulse = (state == FIN);
    end

    // vld_pipe[0] is the registered read strobe; vld_pipe[RD_LAT] marks returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            rd_addr   <= '0;
            rows_left <= '0;
            rows_out  <= '0;
            credits   <= CW'(FD);
            vld_pipe  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            k         <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
            if (issue) begin
                addr      <= addr_inc(issue_addr);
                rd_addr   <= issue_addr;
                rows_left <= rows_base - LW'(1);
            end
            credits <= credits - CW'(issue) + CW'(pop);
            if (start_ok)  rows_out <= bus.x_len;
            else if (pop)  rows_out <= rows_out - LW'(1);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (hs) k <= beat_end ? '0 : k + KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rtm_dout;
    end

    assign head         = mem[rd_ptr];
    assign bus.out_vld  = fifo_vld;
    assign bus.out_data = fifo_vld ? head[k] : '0;
    assign bus.out_last = last_beat;
    assign bus.rtm_rd_vld = vld_pipe[0];

    for (genvar s = 0; s < S; s++) begin : g_slice
        assign bus.rtm_rd_en[s]             = vld_pipe[0];
        assign bus.rtm_rd_addr[s*AW +: AW]  = rd_addr;
    end
endmodule

// File: tb/tb_fc_x_rd.sv
// Table of transfers plus start-while-busy and mid-transfer reset sequences,
// checked against a beat / read-address scoreboard and per-transfer cycle stats.
module tb_fc_x_rd;
    localparam int S = 4, R = 16, RTM_DEPTH = 4096, OUT_BYTES = 16, RD_LAT = 2;
    localparam int AW = 12, LW = AW + 1;
    localparam int N = S * R / OUT_BYTES, ROW_W = S * R * 8, BEAT_W = OUT_BYTES * 8;

    typedef struct { int addr; int len; int rdy_mode; int exp_done; int exp_beats; } vec_t;
    typedef struct { logic [BEAT_W-1:0] data; logic last; } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0, t0 = 0, rdy_mode = 0;
    int n_tests = 0, n_fail = 0;
    int n_rd, n_pop, n_beats, n_last, n_done, n_vld;
    int first_rd, first_vld, busy_rise, done_cyc, busy_at_done, rd_a;
    beat_t exp_q[$];
    int    exp_rd[$];
    beat_t got;
    logic stalled = 1'b0;
    logic [BEAT_W-1:0] hold_data;
    logic hold_last;
    logic [AW-1:0] a_d [RD_LAT];

    fc_x_rd_if #(.S(S), .R(R), .AW(AW), .OUT_BYTES(OUT_BYTES)) bus ();

    fc_x_rd #(.S(S), .R(R), .RTM_DEPTH(RTM_DEPTH), .OUT_BYTES(OUT_BYTES), .RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Row r holds bytes (r*64 + j) mod 256 so every beat of every row is distinct-ish.
    function automatic logic [ROW_W-1:0] row_data(input int row);
        logic [ROW_W-1:0] d;
        for (int j = 0; j < S * R; j++) d[j*8 +: 8] = 8'((row * S * R + j) % 256);
        return d;
    endfunction

    // Fixed-latency RTM model: data follows the slice-0 address RD_LAT cycles later.
    always @(posedge clk) begin
        a_d[0] <= bus.rtm_rd_addr[AW-1:0];
        for (int i = 1; i < RD_LAT; i++) a_d[i] <= a_d[i-1];
    end
    assign bus.rtm_dout = row_data(int'(a_d[RD_LAT-1]));

    initial forever begin
        @(posedge clk);
        #1;
        bus.out_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(99, 0) < 30);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rtm_rd_vld) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc - t0;
                n_tests++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_extra: read of row %0d, none expected", bus.rtm_rd_addr[AW-1:0]);
                end else begin
                    rd_a = exp_rd.pop_front();
                    if (bus.rtm_rd_en !== {S{1'b1}} || bus.rtm_rd_addr !== {S{AW'(rd_a)}}) begin
                        n_fail++;
                        $display("FAIL rd_addr: got en=%b addr=%h, expected en=%b addr=%h",
                                 bus.rtm_rd_en, bus.rtm_rd_addr, {S{1'b1}}, {S{AW'(rd_a)}});
                    end
                end
                n_tests++;
                if (n_rd - n_pop > RD_LAT + 2) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d, expected <= %0d", n_rd - n_pop, RD_LAT + 2);
                end
            end
            if (stalled) begin
                n_tests++;
                if (bus.out_vld !== 1'b1 || bus.out_data !== hold_data || bus.out_last !== hold_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got vld=%b data=%h last=%b, expected vld=1 data=%h last=%b",
                             bus.out_vld, bus.out_data, bus.out_last, hold_data, hold_last);
                end
            end
            stalled   = bus.out_vld && !bus.out_rdy;
            hold_data = bus.out_data;
            hold_last = bus.out_last;
            if (bus.out_vld) begin
                n_vld++;
                if (first_vld < 0) first_vld = cyc - t0;
            end
            if (bus.out_vld && bus.out_rdy) begin
                n_beats++;
                if (bus.out_last) n_last++;
                if (n_beats % N == 0) n_pop++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_extra: got data=%h, no beat expected", bus.out_data);
                end else begin
                    got = exp_q.pop_front();
                    if (bus.out_data !== got.data || bus.out_last !== got.last) begin
                        n_fail++;
                        $display("FAIL beat %0d: got %h last=%b, expected %h last=%b",
                                 n_beats, bus.out_data, bus.out_last, got.data, got.last);
                    end
                end
            end
            if (bus.done_pulse) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc - t0;
                if (bus.busy) busy_at_done = 1;
            end
            if (bus.busy && busy_rise < 0) busy_rise = cyc - t0;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_pop = 0; n_beats = 0; n_last = 0; n_done = 0; n_vld = 0;
        first_rd = -1; first_vld = -1; busy_rise = -1; done_cyc = -1; busy_at_done = 0;
    endtask

    task automatic push_expect(input int addr, input int len);
        logic [ROW_W-1:0] d;
        beat_t b;
        int row;
        for (int r = 0; r < len; r++) begin
            row = (addr + r) % RTM_DEPTH;
            exp_rd.push_back(row);
            d = row_data(row);
            for (int kk = 0; kk < N; kk++) begin
                b.data = d[kk*BEAT_W +: BEAT_W];
                b.last = (r == len - 1) && (kk == N - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic start_xfer(input int addr, input int len);
        clear_stats();
        push_expect(addr, len);
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start_pulse = 1'b1;
        bus.x_addr      = AW'(addr);
        bus.x_len       = LW'(len);
        @(posedge clk);
        #1;
        bus.start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int i = 0;
        while (n_done == 0 && i < max_cyc) begin
            @(posedge clk);
            i++;
        end
        if (n_done == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done_pulse within %0d cycles", max_cyc);
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_beats(input int nb, input int max_cyc);
        int i = 0;
        while (n_beats < nb && i < max_cyc) begin
            @(posedge clk);
            i++;
        end
        chk("beats_before_reset", n_beats, nb);
    endtask

    task automatic check_xfer(input int len, input int exp_done, input int exp_beats);
        chk("done_count", n_done, 1);
        chk("beats", n_beats, exp_beats);
        chk("last_count", n_last, (len > 0) ? 1 : 0);
        chk("reads", n_rd, len);
        chk("first_rd_cyc", first_rd, (len > 0) ? 1 : -1);
        chk("busy_rise_cyc", busy_rise, (len > 0) ? 1 : -1);
        chk("first_vld_cyc", first_vld, (len > 0) ? 2 + RD_LAT : -1);
        chk("busy_at_done", busy_at_done, 0);
        if (exp_done >= 0) chk("done_cyc", done_cyc, exp_done);
        chk("beats_missing", exp_q.size(), 0);
        chk("reads_missing", exp_rd.size(), 0);
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_busy"},      bus.busy, 0);
        chk({pfx, "_done"},      bus.done_pulse, 0);
        chk({pfx, "_rd_vld"},    bus.rtm_rd_vld, 0);
        chk({pfx, "_rd_en"},     bus.rtm_rd_en, 0);
        chk({pfx, "_out_vld"},   bus.out_vld, 0);
        chk({pfx, "_out_last"},  bus.out_last, 0);
        chk({pfx, "_out_data"},  (bus.out_data != '0), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{10,   3,  0, 16, 12};
        vecs[1] = '{0,    8,  1, -1, 32};
        vecs[2] = '{4094, 4,  0, 20, 16};
        vecs[3] = '{0,    0,  0, 1,  0};
        vecs[4] = '{4095, 1,  0, 8,  4};
        vecs[5] = '{200,  12, 0, 52, 48};
        vecs[6] = '{50,   5,  1, -1, 20};

        bus.start_pulse = 1'b0;
        bus.x_addr      = '0;
        bus.x_len       = '0;
        clear_stats();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_quiet("reset");
        chk("reset_rd_addr", bus.rtm_rd_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 7; v++) begin
            rdy_mode = vecs[v].rdy_mode;
            start_xfer(vecs[v].addr, vecs[v].len);
            wait_done(3000);
            check_xfer(vecs[v].len, vecs[v].exp_done, vecs[v].exp_beats);
        end

        // second start mid-transfer must be ignored
        rdy_mode = 0;
        start_xfer(300, 4);
        repeat (3) @(posedge clk);
        #1;
        bus.start_pulse = 1'b1;
        bus.x_addr      = AW'(100);
        bus.x_len       = LW'(2);
        @(posedge clk);
        #1;
        bus.start_pulse = 1'b0;
        wait_done(500);
        check_xfer(4, 20, 16);

        // reset during beat 5 of a 4-row transfer
        start_xfer(20, 4);
        wait_beats(4, 200);
        #2;
        chk("beat5_vld", bus.out_vld, 1);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        exp_q.delete();
        exp_rd.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_stats();
        repeat (10) @(posedge clk);
        chk("post_reset_vld", n_vld, 0);
        chk("post_reset_rd", n_rd, 0);
        chk("post_reset_done", n_done, 0);
        start_xfer(7, 1);
        wait_done(500);
        check_xfer(1, 8, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
